// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline definitions: bubble encoding, fetch FSM states and the IF/DE entry type.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} parking buffer for a response that arrives while decode is stalled.
module fetch_hold_buf
    import rv32_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         wr_en_i,
    input  fetch_entry_t wr_entry_i,
    input  logic         clr_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    // A clear (redirect or release) wins over a simultaneous write.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (wr_en_i) begin
            valid_d = 1'b1;
            entry_d = wr_entry_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, single-outstanding imem reads, IF/DE register. Optional perf counters
// are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        pc_sel_i,
    input  logic        false_path_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic [31:0] instr_fetch_o,
    output logic [31:0] pc_fetch_o,
    output logic [31:0] pc_4_fetch_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_squashed_o,
`endif
    output logic        fetch_valid_o
);

    import rv32_pkg::*;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcf_q, pcf_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;

    logic         req_valid, accept, rsp_drop, rsp_take;
    logic         load;
    fetch_entry_t load_entry;
    logic         hold_wr, hold_clr, hold_valid;
    fetch_entry_t hold_entry;

    // drop_q marks an abandoned read still in flight; no new request until it returns.
    assign req_valid = rst_ni && (state_q == S_REQ) && !drop_q;
    assign accept    = req_valid && imem_req_ready_i;
    assign rsp_drop  = imem_rsp_valid_i && drop_q;
    assign rsp_take  = imem_rsp_valid_i && !drop_q && (state_q == S_WAIT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        load       = 1'b0;
        load_entry = '0;
        hold_wr    = 1'b0;
        hold_clr   = 1'b0;

        if (rsp_drop) begin
            drop_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_drop) begin
                    state_d = S_REQ;
                end else if (rsp_take) begin
                    if (stall_i) begin
                        hold_wr = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        load       = 1'b1;
                        load_entry = '{instr: imem_rsp_data_i, pc: pc_q};
                        pc_d       = pc_q + PC_INC;
                        state_d    = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i && hold_valid) begin
                    load       = 1'b1;
                    load_entry = hold_entry;
                    hold_clr   = 1'b1;
                    pc_d       = pc_q + PC_INC;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything; a read left in flight is marked for dropping.
        if (pc_sel_i) begin
            pc_d     = word_align(branch_target_i);
            load     = 1'b0;
            hold_wr  = 1'b0;
            hold_clr = 1'b1;
            if (((state_q == S_WAIT) && !imem_rsp_valid_i) || accept) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    // An unstalled decode consumes IF/DE every cycle, so anything not refilled becomes a bubble.
    always_comb begin
        instr_d = instr_q;
        pcf_d   = pcf_q;
        valid_d = valid_q;
        if (false_path_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load) begin
                instr_d = load_entry.instr;
                pcf_d   = load_entry.pc;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcf_q   <= RESET_PC;
            valid_q <= 1'b0;
            drop_q  <= ((state_q == S_WAIT) || drop_q) && !imem_rsp_valid_i;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcf_q   <= pcf_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_en_i    (hold_wr),
        .wr_entry_i ('{instr: imem_rsp_data_i, pc: pc_q}),
        .clr_i      (hold_clr),
        .valid_o    (hold_valid),
        .entry_o    (hold_entry)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;
    logic [1:0]  squash_amt;
    logic [32:0] squash_sum;

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        if (load && !false_path_i && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        squash_amt      = {1'b0, false_path_i} + {1'b0, rsp_drop};
        squash_sum      = {1'b0, perf_squashed_q} + {31'b0, squash_amt};
        perf_squashed_d = squash_sum[32] ? 32'hFFFF_FFFF : squash_sum[31:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched_o  = perf_fetched_q;
    assign perf_squashed_o = perf_squashed_q;
`endif

    assign imem_req_valid_o = req_valid;
    assign imem_addr_o      = word_align(pc_q);
    assign instr_fetch_o    = instr_q;
    assign pc_fetch_o       = pcf_q;
    assign pc_4_fetch_o     = pcf_q + PC_INC;
    assign fetch_valid_o    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory responses are driven cycle by cycle.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall;
    logic        pcSel;
    logic        falsePath;
    logic [31:0] branchTarget;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        rspValid;
    logic [31:0] rspData;
    logic [31:0] instrFetch;
    logic [31:0] pcFetch;
    logic [31:0] pc4Fetch;
    logic        fetchValid;

    int checkCount = 0;
    int failCount  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .stall_i          (stall),
        .pc_sel_i         (pcSel),
        .false_path_i     (falsePath),
        .branch_target_i  (branchTarget),
        .imem_req_valid_o (reqValid),
        .imem_req_ready_i (reqReady),
        .imem_addr_o      (reqAddr),
        .imem_rsp_valid_i (rspValid),
        .imem_rsp_data_i  (rspData),
        .instr_fetch_o    (instrFetch),
        .pc_fetch_o       (pcFetch),
        .pc_4_fetch_o     (pc4Fetch),
        .fetch_valid_o    (fetchValid)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, leave outputs settled for sampling.
    task automatic applyStimulus(input logic stallV, input logic pcSelV, input logic falseV,
                                 input logic [31:0] targetV, input logic rspV, input logic [31:0] rspD);
        stall        = stallV;
        pcSel        = pcSelV;
        falsePath    = falseV;
        branchTarget = targetV;
        rspValid     = rspV;
        rspData      = rspD;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0;
        reqReady = 1'b1;
        stall = 1'b0; pcSel = 1'b0; falsePath = 1'b0;
        branchTarget = '0; rspValid = 1'b0; rspData = '0;

        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_instr", instrFetch, NOP);
        checkOutput("rst_pcf", pcFetch, 32'h0);
        checkOutput("rst_pc4", pc4Fetch, 32'h4);
        checkOutput("rst_valid", {31'b0, fetchValid}, 32'h0);
        checkOutput("rst_reqv", {31'b0, reqValid}, 32'h0);

        // Sequential fetch with 1-cycle memory
        rstN = 1'b1;
        #1;
        checkOutput("seq_reqv0", {31'b0, reqValid}, 32'h1);
        checkOutput("seq_addr0", reqAddr, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h1000_0000);
        checkOutput("seq_instr0", instrFetch, 32'h1000_0000);
        checkOutput("seq_pcf0", pcFetch, 32'h0);
        checkOutput("seq_valid0", {31'b0, fetchValid}, 32'h1);
        checkOutput("seq_pc4_0", pc4Fetch, 32'h4);
        checkOutput("seq_addr4", reqAddr, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("seq_bubble", {31'b0, fetchValid}, 32'h0);
        checkOutput("seq_bubble_instr", instrFetch, NOP);
        applyStimulus(0, 0, 0, 0, 1, 32'h1000_0004);
        checkOutput("seq_instr4", instrFetch, 32'h1000_0004);
        checkOutput("seq_addr8", reqAddr, 32'h8);

        // Stall three cycles while a response arrives
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("stl_instr_a", instrFetch, 32'h1000_0004);
        checkOutput("stl_valid_a", {31'b0, fetchValid}, 32'h1);
        applyStimulus(1, 0, 0, 0, 1, 32'h1000_0008);
        checkOutput("stl_instr_b", instrFetch, 32'h1000_0004);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("stl_instr_c", instrFetch, 32'h1000_0004);
        checkOutput("stl_pcf_c", pcFetch, 32'h4);
        checkOutput("stl_hold_noreq", {31'b0, reqValid}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rel_instr", instrFetch, 32'h1000_0008);
        checkOutput("rel_pcf", pcFetch, 32'h8);
        checkOutput("rel_valid", {31'b0, fetchValid}, 32'h1);
        checkOutput("rel_addr", reqAddr, 32'hC);
        checkOutput("rel_reqv", {31'b0, reqValid}, 32'h1);

        // Redirect while a read is in flight
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 32'h0000_0102, 0, 0);
        checkOutput("br_wait_noreq", {31'b0, reqValid}, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        checkOutput("br_drop_instr", instrFetch, NOP);
        checkOutput("br_drop_valid", {31'b0, fetchValid}, 32'h0);
        checkOutput("br_reqv", {31'b0, reqValid}, 32'h1);
        checkOutput("br_addr", reqAddr, 32'h0000_0100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h2000_0100);
        checkOutput("br_instr", instrFetch, 32'h2000_0100);
        checkOutput("br_pcf", pcFetch, 32'h0000_0100);

        // Squash while stalled
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("fp_instr", instrFetch, NOP);
        checkOutput("fp_valid", {31'b0, fetchValid}, 32'h0);
        checkOutput("fp_pcf", pcFetch, 32'h0000_0100);
        applyStimulus(0, 0, 0, 0, 1, 32'h2000_0104);
        checkOutput("fp_next_instr", instrFetch, 32'h2000_0104);
        checkOutput("fp_next_pcf", pcFetch, 32'h0000_0104);

        // PC wrap at the top of the address space
        reqReady = 1'b0;
        applyStimulus(0, 1, 0, 32'hFFFF_FFFC, 0, 0);
        checkOutput("wrap_addr_top", reqAddr, 32'hFFFF_FFFC);
        checkOutput("wrap_reqv", {31'b0, reqValid}, 32'h1);
        reqReady = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h3000_0000);
        checkOutput("wrap_pcf", pcFetch, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", pc4Fetch, 32'h0);
        checkOutput("wrap_addr0", reqAddr, 32'h0);

        // Reset while a read is outstanding; the late response must be ignored
        applyStimulus(0, 0, 0, 0, 0, 0);
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("mrst_instr", instrFetch, NOP);
        checkOutput("mrst_valid", {31'b0, fetchValid}, 32'h0);
        checkOutput("mrst_pcf", pcFetch, 32'h0);
        checkOutput("mrst_reqv", {31'b0, reqValid}, 32'h0);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'hBAD0_0000);
        checkOutput("late_instr", instrFetch, NOP);
        checkOutput("late_valid", {31'b0, fetchValid}, 32'h0);
        checkOutput("late_reqv", {31'b0, reqValid}, 32'h1);
        checkOutput("late_addr", reqAddr, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h1000_0000);
        checkOutput("post_instr", instrFetch, 32'h1000_0000);
        checkOutput("post_pcf", pcFetch, 32'h0);
        checkOutput("post_valid", {31'b0, fetchValid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
